mem_req_arbiter: RTL and testbench

- Shares one SRAM-like request/response port to the cache/AXI-bridge side between the instruction-fetch requester (port I) and the EXE-stage data requester (port D). The data requester covers load/store with the data_sram_* signal set.
- Accepts at most one request per cycle. Holds the grant stable while a request waits for addr_ok.
- Tracks outstanding requests in an in-order tag FIFO so each data_ok/rdata is routed back to the requester that issued it.
- Supports discarding in-flight fetch responses after a pipeline flush.

---
 rtl/mem_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_req_arbiter
// Purpose : I/D requester arbiter onto one SRAM-like port with an in-order tag
//           FIFO routing responses. Optional macro: MEM_ARB_ROUND_ROBIN_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_PTR_W = $clog2(OUTSTANDING);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(OUTSTANDING);
    localparam logic               c_SRC_D = 1'b0;
    localparam logic               c_SRC_I = 1'b1;

    logic [c_CNT_W-1:0]     r_count_q,    w_count_d;
    logic [c_PTR_W-1:0]     r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_PTR_W-1:0]     r_rd_ptr_q,   w_rd_ptr_d;
    logic [OUTSTANDING-1:0] r_src_q,      w_src_d;
    logic [OUTSTANDING-1:0] r_drop_q,     w_drop_d;
    logic                   r_lock_q,     w_lock_d;
    logic                   r_lock_src_q, w_lock_src_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                   r_rr_last_q,  w_rr_last_d;
`endif

    logic w_grant;
    logic w_grant_req;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_head_src;
    logic w_head_drop;

    // A locked grant keeps address and source frozen until the port accepts.
    always_comb begin
        w_grant = c_SRC_D;
        if (r_lock_q) begin
            w_grant = r_lock_src_q;
        end else if (inst_req && !data_req) begin
            w_grant = c_SRC_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        end else if (inst_req && data_req) begin
            w_grant = ~r_rr_last_q;
`endif
        end
    end

    assign w_grant_req = (w_grant == c_SRC_I) ? inst_req : data_req;
    assign w_full      = (r_count_q == c_FULL);

    assign mem_req   = w_grant_req & ~w_full & ~reset;
    assign mem_wr    = (w_grant == c_SRC_I) ? inst_wr    : data_wr;
    assign mem_size  = (w_grant == c_SRC_I) ? inst_size  : data_size;
    assign mem_wstrb = (w_grant == c_SRC_I) ? inst_wstrb : data_wstrb;
    assign mem_addr  = (w_grant == c_SRC_I) ? inst_addr  : data_addr;
    assign mem_wdata = (w_grant == c_SRC_I) ? inst_wdata : data_wdata;

    assign w_push       = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_push & (w_grant == c_SRC_I);
    assign data_addr_ok = w_push & (w_grant == c_SRC_D);

    // A response with nothing outstanding is a stray and leaves all state alone.
    assign w_pop       = mem_data_ok & (r_count_q != '0) & ~reset;
    assign w_head_src  = r_src_q[r_rd_ptr_q];
    assign w_head_drop = r_drop_q[r_rd_ptr_q];

    assign inst_data_ok = w_pop & (w_head_src == c_SRC_I) & ~w_head_drop & ~inst_cancel;
    assign data_data_ok = w_pop & (w_head_src == c_SRC_D);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        logic [c_PTR_W-1:0] w_off;
        w_off    = '0;
        w_src_d  = r_src_q;
        w_drop_d = r_drop_q;
        if (inst_cancel) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                w_off = c_PTR_W'(i) - r_rd_ptr_q;
                if (({1'b0, w_off} < r_count_q) && (r_src_q[i] == c_SRC_I)) begin
                    w_drop_d[i] = 1'b1;
                end
            end
        end
        if (w_push) begin
            w_src_d[r_wr_ptr_q]  = w_grant;
            w_drop_d[r_wr_ptr_q] = inst_cancel & (w_grant == c_SRC_I);
        end

        w_wr_ptr_d = w_push ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - 1'b1;
        end

        w_lock_d     = mem_req & ~mem_addr_ok;
        w_lock_src_d = w_grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_rr_last_d  = w_push ? w_grant : r_rr_last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q    <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_src_q      <= '0;
            r_drop_q     <= '0;
            r_lock_q     <= 1'b0;
            r_lock_src_q <= c_SRC_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_last_q  <= c_SRC_I;
`endif
        end else begin
            r_count_q    <= w_count_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_src_q      <= w_src_d;
            r_drop_q     <= w_drop_d;
            r_lock_q     <= w_lock_d;
            r_lock_src_q <= w_lock_src_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_last_q  <= w_rr_last_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_req_arbiter
// Purpose : Randomized scoreboard bench for mem_req_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int   OUTSTANDING = 4;
    localparam logic c_SRC_D     = 1'b0;
    localparam logic c_SRC_I     = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    mem_req_arbiter #(.OUTSTANDING(OUTSTANDING)) u_dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic        drop;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];     // scoreboard: responses the requesters should see
    logic [31:0] mem_q[$];     // downstream model: read data still owed
    int          n_cmp = 0;
    int          n_err = 0;

    logic pend_i, pend_d;
    logic hold_valid, hold_src;
    logic last_win;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a request already presented but not accepted keeps its source;
    // otherwise the single requester wins, and contention follows the policy.
    task automatic check_request();
        logic exp_src, exp_req;
        exp_t ent;
        if (hold_valid) begin
            exp_src = hold_src;
        end else if (inst_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_src = (last_win == c_SRC_D) ? c_SRC_I : c_SRC_D;
`else
            exp_src = c_SRC_D;
`endif
        end else begin
            exp_src = inst_req ? c_SRC_I : c_SRC_D;
        end
        exp_req = (inst_req || data_req) && (exp_q.size() < OUTSTANDING);

        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) begin
            check("mem_addr",  mem_addr,  exp_src ? inst_addr  : data_addr);
            check("mem_wdata", mem_wdata, exp_src ? inst_wdata : data_wdata);
            check("mem_ctrl",  {27'd0, mem_wr, mem_size, mem_wstrb},
                  exp_src ? {27'd0, inst_wr, inst_size, inst_wstrb}
                          : {27'd0, data_wr, data_size, data_wstrb});
        end
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_req && mem_addr_ok && exp_src == c_SRC_I));
        check("data_addr_ok", 32'(data_addr_ok), 32'(exp_req && mem_addr_ok && exp_src == c_SRC_D));

        if (exp_req && mem_addr_ok) begin
            ent.src   = exp_src;
            ent.drop  = inst_cancel && (exp_src == c_SRC_I);
            ent.rdata = $urandom;
            exp_q.push_back(ent);
            mem_q.push_back(ent.rdata);
            if (exp_src == c_SRC_I) pend_i = 1'b0;
            else                    pend_d = 1'b0;
            last_win   = exp_src;
            hold_valid = 1'b0;
        end else begin
            hold_valid = exp_req;
            hold_src   = exp_src;
        end
    endtask

    task automatic step(input int new_pct, input int rate, input int cancel_pct, input bit stray);
        @(posedge clk); #1;
        if (!pend_i && int'($urandom_range(0, 99)) < new_pct) begin
            pend_i     = 1'b1;
            inst_wr    = ($urandom_range(0, 9) == 0);
            inst_size  = 2'($urandom_range(0, 3));
            inst_wstrb = 4'($urandom_range(0, 15));
            inst_addr  = $urandom;
            inst_wdata = $urandom;
        end
        if (!pend_d && int'($urandom_range(0, 99)) < new_pct) begin
            pend_d     = 1'b1;
            data_wr    = $urandom_range(0, 1) == 1;
            data_size  = 2'($urandom_range(0, 3));
            data_wstrb = 4'($urandom_range(0, 15));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        inst_req    = pend_i;
        data_req    = pend_d;
        mem_addr_ok = int'($urandom_range(0, 99)) < 70;
        if (mem_q.size() > 0 && int'($urandom_range(0, 99)) < rate) begin
            mem_data_ok = 1'b1;
            mem_rdata   = mem_q.pop_front();
        end else begin
            mem_data_ok = stray && (mem_q.size() == 0);
            mem_rdata   = $urandom;
        end
        inst_cancel = int'($urandom_range(0, 99)) < cancel_pct;
        if (inst_cancel) begin
            foreach (exp_q[k]) if (exp_q[k].src == c_SRC_I) exp_q[k].drop = 1'b1;
        end
        @(negedge clk);
        check_request();
    endtask

    // Monitor: every downstream response pops one scoreboard entry.
    always @(negedge clk) begin
        #2;
        if (reset || !mem_data_ok || exp_q.size() == 0) begin
            check("idle_inst_data_ok", 32'(inst_data_ok), 32'd0);
            check("idle_data_data_ok", 32'(data_data_ok), 32'd0);
        end else begin
            mon_e = exp_q.pop_front();
            check("inst_data_ok", 32'(inst_data_ok), 32'(mon_e.src == c_SRC_I && !mon_e.drop));
            check("data_data_ok", 32'(data_data_ok), 32'(mon_e.src == c_SRC_D));
            if (mon_e.src == c_SRC_I && !mon_e.drop) check("inst_rdata", inst_rdata, mon_e.rdata);
            if (mon_e.src == c_SRC_D)                check("data_rdata", data_rdata, mon_e.rdata);
        end
    end

    task automatic clear_model();
        exp_q.delete();
        mem_q.delete();
        pend_i     = 1'b0;
        pend_d     = 1'b0;
        hold_valid = 1'b0;
        hold_src   = c_SRC_D;
        last_win   = c_SRC_I;
    endtask

    initial begin
        int rates[4];
        rates = '{0, 30, 60, 90};
        clear_model();
        reset       = 1'b1;
        inst_req    = 1'b1;  inst_wr = 1'b0;  inst_size = 2'd2;  inst_wstrb = 4'hf;
        inst_addr   = 32'h1000;  inst_wdata = 32'h0;  inst_cancel = 1'b0;
        data_req    = 1'b1;  data_wr = 1'b0;  data_size = 2'd2;  data_wstrb = 4'hf;
        data_addr   = 32'h2000;  data_wdata = 32'h0;
        mem_addr_ok = 1'b1;  mem_data_ok = 1'b1;  mem_rdata = 32'hdead_beef;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req",      32'(mem_req),      32'd0);
        check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;  inst_req = 1'b0;  data_req = 1'b0;  mem_data_ok = 1'b0;

        repeat (5) step(0, 0, 0, 1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) step(50, rates[(cyc / 60) % 4], 6, 1'b0);
        repeat (60) step(0, 100, 0, 1'b0);
        repeat (5) step(0, 0, 0, 1'b1);

        // Reset while entries are outstanding, with a response arriving.
        repeat (12) step(60, 0, 0, 1'b0);
        @(posedge clk); #1;
        reset       = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("midrst_mem_req",      32'(mem_req),      32'd0);
        check("midrst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("midrst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        clear_model();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_data_ok = 1'b0;

        repeat (5) step(0, 0, 0, 1'b1);
        for (int cyc = 0; cyc < 400; cyc++) step(50, rates[(cyc / 40) % 4], 6, 1'b0);
        repeat (60) step(0, 100, 0, 1'b0);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
